// File: rtl/tdp_ram_pkg.sv
// rtl/tdp_ram_pkg.sv - shared constants and helpers for the byte-enable true dual-port RAM
// byte_merge works on a 256-bit container; callers cast to and from their own width.
package tdp_ram_pkg;
    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;
    localparam int MERGE_W        = 256;
    localparam int MERGE_B        = MERGE_W / 8;

    function automatic int word_count(input int addrw, input int word_len);
        return 1 << (addrw - word_len);
    endfunction

    function automatic int byte_count(input int dataw);
        return dataw / 8;
    endfunction

    function automatic logic [MERGE_W-1:0] byte_merge(
        input logic [MERGE_W-1:0] old_word,
        input logic [MERGE_W-1:0] new_word,
        input logic [MERGE_B-1:0] be
    );
        logic [MERGE_W-1:0] r;
        r = old_word;
        for (int i = 0; i < MERGE_B; i++) begin
            if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return r;
    endfunction
endpackage

// File: rtl/tdp_ram_rd_pipe.sv
// rtl/tdp_ram_rd_pipe.sv - per-port read output stage: write-mode select, optional second register, valid
module tdp_ram_rd_pipe
    import tdp_ram_pkg::*;
#(
    parameter int DATAW   = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = WR_READ_FIRST
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [DATAW/8-1:0] we,
    input  logic [DATAW-1:0]   din,
    input  logic [DATAW-1:0]   rd_word,
    output logic [DATAW-1:0]   dout,
    output logic               valid
);
    logic [DATAW-1:0] merged;
    logic [DATAW-1:0] sel;
    logic [DATAW-1:0] d1;
    logic             v1;

    assign merged = DATAW'(byte_merge(MERGE_W'(rd_word), MERGE_W'(din), MERGE_B'(we)));

    always_comb begin
        sel = rd_word;
        if (WR_MODE == WR_WRITE_FIRST) sel = merged;
    end

    // Data only loads on an access so the output holds between valid pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            d1 <= '0;
            v1 <= 1'b0;
        end else begin
            v1 <= en;
            if (en) d1 <= sel;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic [DATAW-1:0] d2;
            logic             v2;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    d2 <= '0;
                    v2 <= 1'b0;
                end else begin
                    d2 <= d1;
                    v2 <= v1;
                end
            end
            assign dout  = d2;
            assign valid = v2;
        end else begin : g_lat1
            assign dout  = d1;
            assign valid = v1;
        end
    endgenerate
endmodule

// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - parametrised true dual-port RAM with byte enables and pipelined valid read
// Optional collision flag coll_o is built when TDP_RAM_COLLISION_DET_EN is defined.
module tdp_ram_be
    import tdp_ram_pkg::*;
#(
    parameter int DATAW    = 32,
    parameter int ADDRW    = 12,
    parameter int WORD_LEN = 2,
    parameter int RD_LAT   = 1,
    parameter int WR_MODE  = WR_READ_FIRST
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               ena,
    input  logic [DATAW/8-1:0] wea,
    input  logic [ADDRW-1:0]   addra,
    input  logic [DATAW-1:0]   dina,
    output logic [DATAW-1:0]   douta,
    output logic               valida,
    input  logic               enb,
    input  logic [DATAW/8-1:0] web,
    input  logic [ADDRW-1:0]   addrb,
    input  logic [DATAW-1:0]   dinb,
    output logic [DATAW-1:0]   doutb,
    output logic               validb
`ifdef TDP_RAM_COLLISION_DET_EN
    ,
    output logic               coll_o
`endif
);
    localparam int NB    = byte_count(DATAW);
    localparam int DEPTH = word_count(ADDRW, WORD_LEN);
    localparam int IDXW  = ADDRW - WORD_LEN;

    logic [DATAW-1:0] mem [DEPTH];
    logic [IDXW-1:0]  idx_a;
    logic [IDXW-1:0]  idx_b;
    logic [DATAW-1:0] rd_a;
    logic [DATAW-1:0] rd_b;
    logic             unused_addr;

    assign idx_a       = addra[ADDRW-1:WORD_LEN];
    assign idx_b       = addrb[ADDRW-1:WORD_LEN];
    assign unused_addr = ^{addra[WORD_LEN-1:0], addrb[WORD_LEN-1:0]};

    // Reads see the array before this edge's writes, giving old data across ports.
    assign rd_a = mem[idx_a];
    assign rd_b = mem[idx_b];

    // Port A is applied last so it wins bytes that both ports write.
    always_ff @(posedge clk) begin
        if (rstn) begin
            for (int i = 0; i < NB; i++) begin
                if (enb && web[i]) mem[idx_b][i*8 +: 8] <= dinb[i*8 +: 8];
                if (ena && wea[i]) mem[idx_a][i*8 +: 8] <= dina[i*8 +: 8];
            end
        end
    end

    tdp_ram_rd_pipe #(.DATAW(DATAW), .RD_LAT(RD_LAT), .WR_MODE(WR_MODE)) u_pipe_a (
        .clk     (clk),
        .rstn    (rstn),
        .en      (ena),
        .we      (wea),
        .din     (dina),
        .rd_word (rd_a),
        .dout    (douta),
        .valid   (valida)
    );

    tdp_ram_rd_pipe #(.DATAW(DATAW), .RD_LAT(RD_LAT), .WR_MODE(WR_MODE)) u_pipe_b (
        .clk     (clk),
        .rstn    (rstn),
        .en      (enb),
        .we      (web),
        .din     (dinb),
        .rd_word (rd_b),
        .dout    (doutb),
        .valid   (validb)
    );

`ifdef TDP_RAM_COLLISION_DET_EN
    logic coll_now;
    logic coll_1;

    assign coll_now = ena && enb && (idx_a == idx_b) && ((|wea) || (|web));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) coll_1 <= 1'b0;
        else       coll_1 <= coll_now;
    end

    generate
        if (RD_LAT == 2) begin : g_coll2
            logic coll_2;
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) coll_2 <= 1'b0;
                else       coll_2 <= coll_1;
            end
            assign coll_o = coll_2;
        end else begin : g_coll1
            assign coll_o = coll_1;
        end
    endgenerate

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && coll_now) $warning("tdp_ram_be: same-word access with write on both ports");
    end
`endif
`endif
endmodule

// File: tb/tb_tdp_ram_be.sv
// tb/tb_tdp_ram_be.sv - bench for tdp_ram_be: two configurations against a word-level reference model
// Instance 0: RD_LAT=1 read-first; instance 1: RD_LAT=2 write-first.
module tb_tdp_ram_be;
    logic        clk  = 1'b0;
    logic        rstn = 1'b0;
    logic        ena, enb;
    logic [3:0]  wea, web;
    logic [11:0] addra, addrb;
    logic [31:0] dina, dinb;
    logic [31:0] douta [2];
    logic [31:0] doutb [2];
    logic        valida [2];
    logic        validb [2];
`ifdef TDP_RAM_COLLISION_DET_EN
    logic        coll [2];
    logic        exp_c [2];
    logic        pend_c;
`endif

    int checks   = 0;
    int failures = 0;
    logic vchk_on = 1'b0;
    logic dchk_on = 1'b0;

    always #5 clk = ~clk;

    tdp_ram_be #(.RD_LAT(1), .WR_MODE(0)) u0 (
        .clk(clk), .rstn(rstn),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[0]), .valida(valida[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[0]), .validb(validb[0])
`ifdef TDP_RAM_COLLISION_DET_EN
        , .coll_o(coll[0])
`endif
    );

    tdp_ram_be #(.RD_LAT(2), .WR_MODE(1)) u1 (
        .clk(clk), .rstn(rstn),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta[1]), .valida(valida[1]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb[1]), .validb(validb[1])
`ifdef TDP_RAM_COLLISION_DET_EN
        , .coll_o(coll[1])
`endif
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one memory, per-edge read records, instance 1 delays them by one edge.
    logic [31:0] mm [1024];
    logic [31:0] exp_d [2][2];
    logic        exp_v [2][2];
    logic [31:0] pend_d [2];
    logic        pend_v [2];
    logic [31:0] m_old [2];
    logic [31:0] m_din [2];
    logic [3:0]  m_we  [2];
    logic        m_en  [2];
    logic [9:0]  m_idx [2];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    exp_d[d][p] = '0;
                    exp_v[d][p] = 1'b0;
                end
                pend_d[d] = '0;
                pend_v[d] = 1'b0;
            end
`ifdef TDP_RAM_COLLISION_DET_EN
            exp_c[0] = 1'b0; exp_c[1] = 1'b0; pend_c = 1'b0;
`endif
        end else begin
            m_en[0] = ena;  m_en[1] = enb;
            m_we[0] = wea;  m_we[1] = web;
            m_din[0] = dina; m_din[1] = dinb;
            m_idx[0] = addra[11:2]; m_idx[1] = addrb[11:2];
            for (int p = 0; p < 2; p++) begin
                m_old[p] = mm[m_idx[p]];
                exp_v[0][p] = m_en[p];
                if (m_en[p]) exp_d[0][p] = m_old[p];
                exp_v[1][p] = pend_v[p];
                if (pend_v[p]) exp_d[1][p] = pend_d[p];
                pend_v[p] = m_en[p];
                if (m_en[p]) pend_d[p] = merge(m_old[p], m_din[p], m_we[p]);
            end
`ifdef TDP_RAM_COLLISION_DET_EN
            exp_c[1] = pend_c;
            exp_c[0] = ena && enb && (m_idx[0] == m_idx[1]) && ((|wea) || (|web));
            pend_c   = exp_c[0];
`endif
            if (enb) mm[m_idx[1]] = merge(mm[m_idx[1]], dinb, web);
            if (ena) mm[m_idx[0]] = merge(mm[m_idx[0]], dina, wea);
        end
    end

    always @(negedge clk) begin
        if (vchk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("u%0d_valida", d), 32'(valida[d]), 32'(exp_v[d][0]));
                chk($sformatf("u%0d_validb", d), 32'(validb[d]), 32'(exp_v[d][1]));
                if (dchk_on) begin
                    chk($sformatf("u%0d_douta", d), douta[d], exp_d[d][0]);
                    chk($sformatf("u%0d_doutb", d), doutb[d], exp_d[d][1]);
                end
`ifdef TDP_RAM_COLLISION_DET_EN
                chk($sformatf("u%0d_coll", d), 32'(coll[d]), 32'(exp_c[d]));
`endif
            end
        end
    end

    task automatic set_a(input logic en, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
        ena = en; wea = we; addra = a; dina = d;
    endtask

    task automatic set_b(input logic en, input logic [3:0] we, input logic [11:0] a, input logic [31:0] d);
        enb = en; web = we; addrb = a; dinb = d;
    endtask

    task automatic idle();
        set_a(1'b0, 4'h0, 12'h0, 32'h0);
        set_b(1'b0, 4'h0, 12'h0, 32'h0);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        idle();
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_douta", douta[d], 32'h0);
            chk("rst_doutb", doutb[d], 32'h0);
            chk("rst_valida", 32'(valida[d]), 32'h0);
            chk("rst_validb", 32'(validb[d]), 32'h0);
        end
        rstn = 1'b1;
        vchk_on = 1'b1;

        for (int w = 0; w < 16; w += 2) begin
            set_a(1'b1, 4'hF, 12'(w * 4), 32'h01010101 * w);
            set_b(1'b1, 4'hF, 12'((w + 1) * 4), 32'h01010101 * (w + 1));
            step();
        end
        for (int w = 0; w < 16; w += 2) begin
            set_a(1'b1, 4'h0, 12'(w * 4), 32'h0);
            set_b(1'b1, 4'h0, 12'((w + 1) * 4), 32'h0);
            step();
        end
        idle();
        repeat (3) step();
        dchk_on = 1'b1;

        // write then cross-port read after it
        set_a(1'b1, 4'hF, 12'h010, 32'hDEADBEEF); step();
        set_a(1'b0, 4'h0, 12'h0, 32'h0); set_b(1'b1, 4'h0, 12'h010, 32'h0); step();
        chk("lat1_validb", 32'(validb[0]), 32'h1);
        chk("lat1_doutb", doutb[0], 32'hDEADBEEF);
        chk("lat2_validb_early", 32'(validb[1]), 32'h0);
        idle(); step();
        chk("lat2_validb", 32'(validb[1]), 32'h1);
        chk("lat2_doutb", doutb[1], 32'hDEADBEEF);
        chk("lat1_validb_drop", 32'(validb[0]), 32'h0);
        chk("lat1_doutb_hold", doutb[0], 32'hDEADBEEF);

        // byte enables
        set_a(1'b1, 4'hF, 12'h000, 32'h11223344); step();
        set_a(1'b1, 4'b0101, 12'h000, 32'hAABBCCDD); step();
        set_a(1'b0, 4'h0, 12'h0, 32'h0); set_b(1'b1, 4'h0, 12'h000, 32'h0); step();
        chk("be_u0", doutb[0], 32'h11BB33DD);
        idle(); step();
        chk("be_u1", doutb[1], 32'h11BB33DD);

        // same-port read-during-write
        set_a(1'b1, 4'hF, 12'h004, 32'h0); step();
        set_a(1'b1, 4'hF, 12'h004, 32'h5A5A5A5A); step();
        chk("rdw_read_first", douta[0], 32'h00000000);
        idle(); step();
        chk("rdw_write_first", douta[1], 32'h5A5A5A5A);

        // dual write to one word
        set_a(1'b1, 4'b0011, 12'h008, 32'h000000AA);
        set_b(1'b1, 4'hF, 12'h008, 32'hBBBBBBBB); step();
        idle(); set_a(1'b1, 4'h0, 12'h008, 32'h0); step();
        chk("dual_u0", douta[0], 32'hBBBB00AA);
        idle(); step();
        chk("dual_u1", douta[1], 32'hBBBB00AA);

        // cross-port read of a word being written
        set_a(1'b1, 4'hF, 12'h00C, 32'h1); step();
        set_a(1'b1, 4'hF, 12'h00C, 32'h2); set_b(1'b1, 4'h0, 12'h00C, 32'h0); step();
        chk("xport_old_u0", doutb[0], 32'h1);
        idle(); step();
        chk("xport_old_u1", doutb[1], 32'h1);
        set_b(1'b1, 4'h0, 12'h00C, 32'h0); step();
        chk("xport_new_u0", doutb[0], 32'h2);
        idle(); step();
        chk("xport_new_u1", doutb[1], 32'h2);

        // reset in the middle of a read stream
        set_a(1'b1, 4'h0, 12'h010, 32'h0);
        repeat (4) step();
        #2 rstn = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("async_rst_valida", 32'(valida[d]), 32'h0);
            chk("async_rst_douta", douta[d], 32'h0);
        end
        set_a(1'b1, 4'hF, 12'h000, 32'hFFFFFFFF);
        repeat (2) step();
        rstn = 1'b1;
        set_a(1'b1, 4'h0, 12'h000, 32'h0); step();
        chk("post_rst_u0_valid", 32'(valida[0]), 32'h1);
        chk("post_rst_u0_data", douta[0], 32'h11BB33DD);
        chk("post_rst_u1_early", 32'(valida[1]), 32'h0);
        step();
        chk("post_rst_u1_valid", 32'(valida[1]), 32'h1);
        chk("post_rst_u1_data", douta[1], 32'h11BB33DD);

        // randomized traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            set_a($urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  12'({$urandom_range(0, 15), 2'($urandom)}), $urandom);
            set_b($urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                  12'({$urandom_range(0, 15), 2'($urandom)}), $urandom);
            step();
        end
        idle();
        repeat (3) step();
        vchk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
